apb_master: RTL
===============

# apb_master

Single-outstanding APB requester that turns a simple valid/ready request from a core-side unit (load/store path, DMA, test sequencer) into a compliant APB SETUP/ACCESS transfer, then returns read data and error status on a held response channel. It drives the `apb_if` master modport and sits between internal initiators and the APB slave fabric, including the on-chip memory-model slaves. It includes a configurable ACCESS-phase timeout and early rejection of illegal requests.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: maximum ACCESS cycles waiting for `ready`; 0 disables the timeout.
- `ADDR_W`, default 32: request and APB address width.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block accepts request (IDLE only).
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  write data.
- `req_strb`  in  4  write strobes; legal values are 1111, 0011, and 0001.
- `rsp_valid`  out  1  response held until accepted.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_rdata`  out  32  read data; 0 for writes and errors.
- `rsp_err`  out  1  slverr, illegal request, or timeout.
- `rsp_timeout`  out  1  error cause was a timeout.
- `apb`  modport  `apb_if.master`  drives `addr`, `sel`, `enable`, `write`, `wdata`, `strb`; samples `rdata`, `ready`, `slverr`.

## Operation
- FSM states are IDLE, SETUP, ACCESS and RESP. Reset enters IDLE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid && req_ready`, register `addr`, `write`, `wdata` and `strb`. For reads, register `strb` as 0000.
  - A request is illegal if `addr[1:0]`≠0, or if it is a write with a strobe outside {1111, 0011, 0001}.
  - Illegal request: go to RESP with `rsp_err`=1. No APB activity occurs.
  - Legal request: go to SETUP.
- SETUP: `sel`=1, `enable`=0. Go unconditionally to ACCESS.
- ACCESS:
  - `sel`=1, `enable`=1. The timeout counter increments each cycle `ready`=0.
  - On `ready`=1:
    - Capture `rdata` (reads only) and `slverr` into `rsp_err`.
    - Deassert `sel` and `enable` next cycle, then go to RESP.
  - If the counter reaches `TIMEOUT_CYCLES` (nonzero) without `ready`:
    - Drop `sel` and `enable`.
    - Set `rsp_err`=1 and `rsp_timeout`=1, then go to RESP.
- RESP: `rsp_valid`=1 with stable data. On `rsp_ready`, go to IDLE.
- `addr`, `write`, `wdata` and `strb` stay stable from SETUP through the last ACCESS cycle. They hold their last value while idle.
- Exactly one transfer is outstanding. A new request is never accepted while RESP is pending.
- Reset asserted in any state:
  - Next edge: IDLE, `sel`/`enable`/`rsp_valid`=0.
  - Response registers and counter clear; an in-flight transfer is abandoned.

## Timing
- Reset values (all outputs): `apb.sel`, `apb.enable`, `apb.write`=0; `apb.addr`, `apb.wdata`, `apb.strb`=0; `rsp_valid`, `rsp_err`, `rsp_timeout`=0; `rsp_rdata`=0.
- `req_ready` is 0 while `rst`=1. It is 1 in the first cycle after reset release.
- Accept edge = T0:
  - SETUP visible T0+1, ACCESS T0+2.
  - With zero-wait `ready`, completion edge is T0+3 and `rsp_valid` is 1 from T0+3.
  - Each wait cycle adds 1.
- Illegal request: `rsp_valid` at T0+1. `sel` is never asserted.
- Timeout: exactly `TIMEOUT_CYCLES` ACCESS cycles with `ready`=0, then `rsp_valid` on the next cycle.
- If `ready` arrives in the same cycle the counter hits the limit, `ready` wins: normal completion, no timeout.
- Back-to-back throughput: after the `rsp_ready` handshake, IDLE lasts one cycle. Minimum 4 cycles per transfer.
- `rsp_*` are registered outputs. `req_ready` is decoded from state.

## Structure
- Shared package `apb_pkg`:
  - `apb_state_e` enum (IDLE/SETUP/ACCESS/RESP).
  - Legal-strobe constants `STRB_WORD`=1111, `STRB_HALF`=0011, `STRB_BYTE`=0001.
  - `apb_req_t`/`apb_rsp_t` structs for the request/response bundles.
- One natural sub-module: `apb_timeout_ctr`. It has a clear/enable/expire counter, width `$clog2(TIMEOUT_CYCLES+1)`, and tie-off when `TIMEOUT_CYCLES`=0.

## Test plan
- Zero-wait write then read:
  - Write addr 0x10, data 0xDEADBEEF, strb 1111, then read 0x10.
  - Required: `rdata`=0xDEADBEEF, `rsp_err`=0, `rsp_valid` at T0+3, and SETUP/ACCESS phase ordering correct.
- Wait states:
  - Slave holds `ready`=0 for 5 ACCESS cycles.
  - Required: `addr`/`wdata`/`strb` stable throughout, and `rsp_valid` at T0+8.
- Illegal requests:
  - Read at addr 0x13 gives `rsp_err`=1 at T0+1 with no `sel`.
  - Write with strb 0110 gives the same result.
- Timeout and boundary:
  - `TIMEOUT_CYCLES`=4 with a slave that never readies: `sel` drops after 4 ACCESS cycles, `rsp_err`=1, `rsp_timeout`=1.
  - `ready` asserted on the 4th cycle: normal completion.
- Backpressure and reset:
  - Hold `rsp_ready`=0 for 10 cycles: response stays stable and `req_ready`=0.
  - Assert `rst` mid-ACCESS: next cycle `sel`/`enable`=0, state IDLE, `rsp_valid`=0.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared types and constants for the APB requester.
//   apb_state_e  - requester FSM states
//   STRB_*       - the only write strobe patterns the requester will issue
//   apb_req_t    - registered request bundle (write, wdata, strb)
//   apb_rsp_t    - registered response bundle (rdata, err, timeout)
//   req_is_legal - early rejection check for alignment and strobe pattern
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam logic [3:0] STRB_WORD = 4'b1111;
    localparam logic [3:0] STRB_HALF = 4'b0011;
    localparam logic [3:0] STRB_BYTE = 4'b0001;

    typedef struct packed {
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } apb_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        timeout;
    } apb_rsp_t;

    // Reads ignore the strobe; writes must use one of the three patterns.
    function automatic logic req_is_legal(input logic       write,
                                          input logic [1:0] addr_lo,
                                          input logic [3:0] strb);
        logic strb_ok;
        strb_ok = (strb == STRB_WORD) || (strb == STRB_HALF) || (strb == STRB_BYTE);
        return (addr_lo == 2'b00) && (!write || strb_ok);
    endfunction

endpackage

// File: rtl/apb_if.sv
// apb_if: APB bus bundle between one requester and the slave fabric.
//   master modport: drives addr/sel/enable/write/wdata/strb, samples rdata/ready/slverr
//   slave  modport: the mirror image
interface apb_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic              sel;
    logic              enable;
    logic              write;
    logic [31:0]       wdata;
    logic [3:0]        strb;
    logic [31:0]       rdata;
    logic              ready;
    logic              slverr;

    modport master (
        output addr, sel, enable, write, wdata, strb,
        input  rdata, ready, slverr
    );

    modport slave (
        input  addr, sel, enable, write, wdata, strb,
        output rdata, ready, slverr
    );
endinterface

// File: rtl/apb_timeout_ctr.sv
// apb_timeout_ctr: ACCESS-phase wait watchdog.
//   clk, rst - clock and synchronous active-high reset
//   clear    - reload the budget (asserted in the cycle before ACCESS)
//   en       - one ACCESS cycle passed without ready
//   expire   - this un-ready cycle is the last one allowed
// Implemented as a down-counter loaded with TIMEOUT_CYCLES; expire is the
// terminal-count compare qualified by en, so the caller can still let a
// same-cycle ready take priority. TIMEOUT_CYCLES = 0 ties expire low.
module apb_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expire
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, clear, en};
            assign expire = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES);

            logic [CW-1:0] cnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= LOAD;
                end else if (en && (cnt != '0)) begin
                    cnt <= cnt - CW'(1);
                end
            end

            assign expire = en && (cnt == CW'(1));
        end
    endgenerate

endmodule

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester.
//   clk, rst         - clock, synchronous active-high reset
//   req_*            - valid/ready request channel (accepted in IDLE only)
//   rsp_*            - registered response held until rsp_ready
//   apb              - APB master modport
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | req_ready high; register request, reject illegal ones
//   SETUP  | sel=1, enable=0, timeout budget reloaded
//   ACCESS | sel=1, enable=1, wait for ready or timeout
//   RESP   | rsp_valid held with stable data until rsp_ready
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int          ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_strb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    apb_if.master             apb
);

    apb_state_e        state;
    logic [ADDR_W-1:0] addr_q;
    apb_req_t          req_q;
    apb_rsp_t          rsp_q;
    logic              sel_q;
    logic              enable_q;
    logic              rsp_valid_q;

    logic tmo_clear;
    logic tmo_en;
    logic tmo_expire;

    assign tmo_clear = (state == SETUP);
    assign tmo_en    = (state == ACCESS) && !apb.ready;

    apb_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmo_clear),
        .en     (tmo_en),
        .expire (tmo_expire)
    );

    // Gated by rst so nothing can be accepted in the reset cycle itself.
    assign req_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            req_q       <= '0;
            rsp_q       <= '0;
            sel_q       <= 1'b0;
            enable_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q      <= req_addr;
                        req_q.write <= req_write;
                        req_q.wdata <= req_wdata;
                        req_q.strb  <= req_write ? req_strb : 4'b0000;
                        if (req_is_legal(req_write, req_addr[1:0], req_strb)) begin
                            sel_q <= 1'b1;
                            state <= SETUP;
                        end else begin
                            // Rejected without touching the bus.
                            rsp_q.rdata   <= '0;
                            rsp_q.err     <= 1'b1;
                            rsp_q.timeout <= 1'b0;
                            rsp_valid_q   <= 1'b1;
                            state         <= RESP;
                        end
                    end
                end
                SETUP: begin
                    enable_q <= 1'b1;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    // ready is checked first so a last-cycle ready still completes.
                    if (apb.ready) begin
                        sel_q         <= 1'b0;
                        enable_q      <= 1'b0;
                        rsp_q.rdata   <= (req_q.write || apb.slverr) ? '0 : apb.rdata;
                        rsp_q.err     <= apb.slverr;
                        rsp_q.timeout <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state         <= RESP;
                    end else if (tmo_expire) begin
                        sel_q         <= 1'b0;
                        enable_q      <= 1'b0;
                        rsp_q.rdata   <= '0;
                        rsp_q.err     <= 1'b1;
                        rsp_q.timeout <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign apb.addr    = addr_q;
    assign apb.sel     = sel_q;
    assign apb.enable  = enable_q;
    assign apb.write   = req_q.write;
    assign apb.wdata   = req_q.wdata;
    assign apb.strb    = req_q.strb;

    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_q.rdata;
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

endmodule
